// File: rtl/spi_rd_arbiter_pkg.sv
// Shared constants, state encoding and word formatting for the SPI read arbiter.
// Header and trailer words are {mark[3:0], flag, channel[2:0], count[7:0]}.
package spi_rd_arbiter_pkg;

  localparam logic [3:0]  HDR_MARK  = 4'hA;
  localparam logic [3:0]  TRL_MARK  = 4'hC;
  localparam logic [15:0] FILL_WORD = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_HDR  = 3'd2,
    ST_DATA = 3'd3,
    ST_END  = 3'd4
  } state_e;

  function automatic logic [15:0] make_word(input logic [3:0] mark,
                                            input logic       flag,
                                            input logic [2:0] ch,
                                            input logic [7:0] count);
    return {mark, flag, ch, count};
  endfunction

endpackage

// File: rtl/spi_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first non-empty channel after 'last', wrapping mod N_CH.
module spi_rr_pick #(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0] nonempty_i,
  input  logic [2:0]      last_i,
  output logic            found_o,
  output logic [2:0]      idx_o
);

  // Walk from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = last_i;
    for (int k = N_CH; k >= 1; k--) begin
      for (int i = 0; i < N_CH; i++) begin
        if (nonempty_i[i] && (i == (int'(last_i) + k) % N_CH)) begin
          found_o = 1'b1;
          idx_o   = 3'(i);
        end
      end
    end
  end

endmodule

// File: rtl/spi_rd_arbiter.sv
// Round-robin arbiter sharing the SPI read path between N_CH FWFT channel FIFOs.
// Define SPI_ARB_TRAILER_EN to append a trailer word {4'hC, 0, ch, sent} after each burst.
module spi_rd_arbiter #(
  parameter int N_CH      = 4,
  parameter int DATA_W    = 16,
  parameter int LW        = 10,
  parameter int MAX_BURST = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_start_i,
  input  logic                     word_req_i,
  input  logic                     abort_i,
  input  logic [N_CH*LW-1:0]       ch_level_i,
  input  logic [N_CH*DATA_W-1:0]   ch_data_i,
  output logic [N_CH-1:0]          ch_rd_en_o,
  output logic [DATA_W-1:0]        tx_data_o,
  output logic                     tx_valid_o,
  output logic                     busy_o,
  output logic [2:0]               grant_ch_o
);

  import spi_rd_arbiter_pkg::*;

  state_e              state_q, state_d;
  logic [2:0]          grant_q, grant_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          sent_q, sent_d;
  logic                empty_q, empty_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;

  logic [LW-1:0]       level [N_CH];
  logic [DATA_W-1:0]   head  [N_CH];
  logic [N_CH-1:0]     nonempty;
  logic                pick_found;
  logic [2:0]          pick_idx;
  logic [LW-1:0]       pick_level;
  logic [DATA_W-1:0]   grant_head;
  logic [7:0]          burst_len;
  logic                pop;

  for (genvar g = 0; g < N_CH; g++) begin : g_unpack
    assign level[g]    = ch_level_i[g*LW +: LW];
    assign head[g]     = ch_data_i[g*DATA_W +: DATA_W];
    assign nonempty[g] = |level[g];
  end

  spi_rr_pick #(.N_CH(N_CH)) u_pick (
    .nonempty_i (nonempty),
    .last_i     (grant_q),
    .found_o    (pick_found),
    .idx_o      (pick_idx)
  );

  always_comb begin
    pick_level = '0;
    grant_head = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (pick_idx == 3'(i)) pick_level = level[i];
      if (grant_q == 3'(i))  grant_head = head[i];
    end
    if (32'(pick_level) > 32'(MAX_BURST)) burst_len = 8'(MAX_BURST);
    else                                  burst_len = 8'(pick_level);
  end

  // Abort suppresses the pop so the word stays in the FIFO for the next read.
  assign pop = word_req_i & ~abort_i & (state_q == ST_DATA) & (cnt_q != 8'd0);

  always_comb begin
    for (int i = 0; i < N_CH; i++) ch_rd_en_o[i] = pop & (grant_q == 3'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (rd_start_i) state_d = ST_ARB;
        ST_ARB:  state_d = ST_HDR;
        ST_HDR:  if (word_req_i) state_d = (cnt_q != 8'd0) ? ST_DATA : ST_END;
        ST_DATA: if (word_req_i && cnt_q == 8'd1) state_d = ST_END;
`ifdef SPI_ARB_TRAILER_EN
        ST_END:  if (word_req_i) state_d = ST_IDLE;
`else
        ST_END:  state_d = ST_IDLE;
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    sent_d     = sent_q;
    empty_d    = empty_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    if (!abort_i) begin
      case (state_q)
        ST_IDLE: begin
          if (word_req_i) begin
            tx_data_d  = DATA_W'(FILL_WORD);
            tx_valid_d = 1'b1;
          end
        end
        ST_ARB: begin
          if (word_req_i) begin
            tx_data_d  = DATA_W'(FILL_WORD);
            tx_valid_d = 1'b1;
          end
          sent_d = 8'd0;
          if (pick_found) begin
            grant_d = pick_idx;
            cnt_d   = burst_len;
            empty_d = 1'b0;
          end else begin
            cnt_d   = 8'd0;
            empty_d = 1'b1;
          end
        end
        ST_HDR: begin
          if (word_req_i) begin
            tx_data_d  = DATA_W'(make_word(HDR_MARK, empty_q, grant_q, cnt_q));
            tx_valid_d = 1'b1;
          end
        end
        ST_DATA: begin
          if (word_req_i) begin
            tx_data_d  = grant_head;
            tx_valid_d = 1'b1;
            cnt_d      = cnt_q - 8'd1;
            sent_d     = sent_q + 8'd1;
          end
        end
        ST_END: begin
          if (word_req_i) begin
`ifdef SPI_ARB_TRAILER_EN
            tx_data_d  = DATA_W'(make_word(TRL_MARK, 1'b0, grant_q, sent_q));
`else
            tx_data_d  = DATA_W'(FILL_WORD);
`endif
            tx_valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q    <= 3'(N_CH - 1);
      cnt_q      <= 8'd0;
      sent_q     <= 8'd0;
      empty_q    <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      sent_q     <= sent_d;
      empty_q    <= empty_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign grant_ch_o = grant_q;

endmodule

// File: tb/tb_spi_rd_arbiter.sv
// Directed bench for spi_rd_arbiter; FIFO heads are {ch+1, pop index} so word order is visible.
module tb_spi_rd_arbiter;

  localparam int N_CH      = 4;
  localparam int DATA_W    = 16;
  localparam int LW        = 10;
  localparam int MAX_BURST = 64;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   rd_start;
  logic                   word_req;
  logic                   abort;
  logic [N_CH*LW-1:0]     ch_level;
  logic [N_CH*DATA_W-1:0] ch_data;
  logic [N_CH-1:0]        ch_rd_en;
  logic [DATA_W-1:0]      tx_data;
  logic                   tx_valid;
  logic                   busy;
  logic [2:0]             grant_ch;

  logic [LW-1:0] base_lvl [N_CH];
  logic [LW-1:0] pop_cnt  [N_CH] = '{default: '0};
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_rd_arbiter #(
    .N_CH(N_CH), .DATA_W(DATA_W), .LW(LW), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_start_i (rd_start),
    .word_req_i (word_req),
    .abort_i    (abort),
    .ch_level_i (ch_level),
    .ch_data_i  (ch_data),
    .ch_rd_en_o (ch_rd_en),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .busy_o     (busy),
    .grant_ch_o (grant_ch)
  );

  // FWFT FIFO model: level is refill total minus pops, head word tags channel and pop index.
  always @(posedge clk) begin
    for (int i = 0; i < N_CH; i++)
      if (ch_rd_en[i]) pop_cnt[i] <= pop_cnt[i] + 1'b1;
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      ch_level[i*LW +: LW]         = base_lvl[i] - pop_cnt[i];
      ch_data[i*DATA_W +: DATA_W]  = DATA_W'((i + 1) << 12) | DATA_W'(pop_cnt[i]);
    end
  end

  task automatic tick(input logic rs, input logic ab);
    rd_start = rs;
    abort    = ab;
    @(posedge clk);
    #1;
    rd_start = 1'b0;
    abort    = 1'b0;
  endtask

  task automatic send_word(output logic [15:0] d, output logic v, output logic [N_CH-1:0] en);
    word_req = 1'b1;
    #1;
    en = ch_rd_en;
    @(posedge clk);
    #1;
    d = tx_data;
    v = tx_valid;
    word_req = 1'b0;
  endtask

  task automatic start_read();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic finish_burst(output logic [15:0] d, output logic v);
`ifdef SPI_ARB_TRAILER_EN
    logic [N_CH-1:0] en;
    send_word(d, v, en);
`else
    d = '0;
    v = 1'b0;
    tick(1'b0, 1'b0);
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_start = 1'b0; word_req = 1'b0; abort = 1'b0;
    for (int i = 0; i < N_CH; i++) base_lvl[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (tx_data !== 16'h0000 || tx_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_tx: got %h/%b expected 0000/0", tx_data, tx_valid);
    end
    n_checks++;
    if (busy !== 1'b0 || grant_ch !== 3'd3 || ch_rd_en !== 4'b0000) begin
      n_fail++; $display("[TB] FAIL reset_state: got busy=%b grant=%0d en=%b expected 0/3/0000", busy, grant_ch, ch_rd_en);
    end
  endtask

  task automatic test_basic_burst();
    logic [15:0] d; logic v; logic [N_CH-1:0] en;
    base_lvl[1] = 10'd5; base_lvl[3] = 10'd3;
    start_read();
    n_checks++;
    if (busy !== 1'b1 || grant_ch !== 3'd1) begin
      n_fail++; $display("[TB] FAIL basic_grant: got busy=%b grant=%0d expected 1/1", busy, grant_ch);
    end
    send_word(d, v, en);
    n_checks++;
    if (d !== 16'hA105 || v !== 1'b1 || en !== 4'b0000) begin
      n_fail++; $display("[TB] FAIL basic_hdr: got %h v=%b en=%b expected A105 v=1 en=0000", d, v, en);
    end
    for (int k = 0; k < 5; k++) begin
      send_word(d, v, en);
      n_checks++;
      if (d !== 16'h2000 + 16'(k) || v !== 1'b1 || en !== 4'b0010) begin
        n_fail++; $display("[TB] FAIL basic_data%0d: got %h v=%b en=%b expected %h v=1 en=0010", k, d, v, en, 16'h2000 + 16'(k));
      end
    end
    send_word(d, v, en);
`ifdef SPI_ARB_TRAILER_EN
    n_checks++;
    if (d !== 16'hC105 || v !== 1'b1) begin
      n_fail++; $display("[TB] FAIL basic_trailer: got %h v=%b expected C105 v=1", d, v);
    end
`else
    n_checks++;
    if (d !== 16'h0000 || v !== 1'b1) begin
      n_fail++; $display("[TB] FAIL basic_fill: got %h v=%b expected 0000 v=1", d, v);
    end
`endif
    n_checks++;
    if (en !== 4'b0000 || busy !== 1'b0 || pop_cnt[1] !== 10'd5) begin
      n_fail++; $display("[TB] FAIL basic_end: got en=%b busy=%b pops=%0d expected 0000/0/5", en, busy, pop_cnt[1]);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] d; logic v; logic [N_CH-1:0] en;
    start_read();
    send_word(d, v, en);
    n_checks++;
    if (d !== 16'hA303 || grant_ch !== 3'd3) begin
      n_fail++; $display("[TB] FAIL rr_hdr_ch3: got %h grant=%0d expected A303 grant=3", d, grant_ch);
    end
    for (int k = 0; k < 3; k++) begin
      send_word(d, v, en);
      n_checks++;
      if (d !== 16'h4000 + 16'(k) || en !== 4'b1000) begin
        n_fail++; $display("[TB] FAIL rr_data_ch3_%0d: got %h en=%b expected %h en=1000", k, d, en, 16'h4000 + 16'(k));
      end
    end
    finish_burst(d, v);
`ifdef SPI_ARB_TRAILER_EN
    n_checks++;
    if (d !== 16'hC303) begin
      n_fail++; $display("[TB] FAIL rr_trailer_ch3: got %h expected C303", d);
    end
`endif
    base_lvl[1] = 10'd9;
    start_read();
    send_word(d, v, en);
    n_checks++;
    if (d !== 16'hA104 || grant_ch !== 3'd1) begin
      n_fail++; $display("[TB] FAIL rr_wrap_hdr: got %h grant=%0d expected A104 grant=1", d, grant_ch);
    end
    for (int k = 0; k < 4; k++) begin
      send_word(d, v, en);
      n_checks++;
      if (d !== 16'h2005 + 16'(k) || en !== 4'b0010) begin
        n_fail++; $display("[TB] FAIL rr_wrap_data%0d: got %h en=%b expected %h en=0010", k, d, en, 16'h2005 + 16'(k));
      end
    end
    finish_burst(d, v);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rr_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_empty();
    logic [15:0] d; logic v; logic [N_CH-1:0] en;
    start_read();
    send_word(d, v, en);
    n_checks++;
    if (d !== 16'hA900 || en !== 4'b0000 || busy !== 1'b1) begin
      n_fail++; $display("[TB] FAIL empty_hdr: got %h en=%b busy=%b expected A900/0000/1", d, en, busy);
    end
    finish_burst(d, v);
`ifdef SPI_ARB_TRAILER_EN
    n_checks++;
    if (d !== 16'hC100) begin
      n_fail++; $display("[TB] FAIL empty_trailer: got %h expected C100", d);
    end
`endif
    n_checks++;
    if (busy !== 1'b0 || grant_ch !== 3'd1) begin
      n_fail++; $display("[TB] FAIL empty_end: got busy=%b grant=%0d expected 0/1", busy, grant_ch);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d; logic v; logic [N_CH-1:0] en;
    base_lvl[0] = 10'd100;
    start_read();
    send_word(d, v, en);
    n_checks++;
    if (d !== 16'hA040 || grant_ch !== 3'd0) begin
      n_fail++; $display("[TB] FAIL b2b_hdr: got %h grant=%0d expected A040 grant=0", d, grant_ch);
    end
    for (int k = 0; k < 64; k++) begin
      send_word(d, v, en);
      n_checks++;
      if (d !== 16'h1000 + 16'(k) || v !== 1'b1 || en !== 4'b0001) begin
        n_fail++; $display("[TB] FAIL b2b_data%0d: got %h v=%b en=%b expected %h v=1 en=0001", k, d, v, en, 16'h1000 + 16'(k));
      end
    end
    finish_burst(d, v);
`ifdef SPI_ARB_TRAILER_EN
    n_checks++;
    if (d !== 16'hC040) begin
      n_fail++; $display("[TB] FAIL b2b_trailer: got %h expected C040", d);
    end
`endif
    n_checks++;
    if (pop_cnt[0] !== 10'd64 || ch_level[0 +: LW] !== 10'd36 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL b2b_count: got pops=%0d level=%0d busy=%b expected 64/36/0", pop_cnt[0], ch_level[0 +: LW], busy);
    end
  endtask

  task automatic test_fill_start();
    rd_start = 1'b1;
    word_req = 1'b1;
    @(posedge clk);
    #1;
    rd_start = 1'b0;
    word_req = 1'b0;
    n_checks++;
    if (tx_data !== 16'h0000 || tx_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("[TB] FAIL fill_start: got %h v=%b busy=%b expected 0000/1/1", tx_data, tx_valid, busy);
    end
    tick(1'b0, 1'b1);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL fill_abort: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_abort_and_reset();
    logic [15:0] d; logic v; logic [N_CH-1:0] en;
    base_lvl[0] = 10'd164;
    start_read();
    send_word(d, v, en);
    for (int k = 0; k < 2; k++) begin
      send_word(d, v, en);
      n_checks++;
      if (d !== 16'h1040 + 16'(k)) begin
        n_fail++; $display("[TB] FAIL abort_data%0d: got %h expected %h", k, d, 16'h1040 + 16'(k));
      end
    end
    abort = 1'b1;
    word_req = 1'b1;
    #1;
    en = ch_rd_en;
    @(posedge clk);
    #1;
    abort = 1'b0;
    word_req = 1'b0;
    n_checks++;
    if (en !== 4'b0000 || busy !== 1'b0 || tx_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL abort_stop: got en=%b busy=%b v=%b expected 0000/0/0", en, busy, tx_valid);
    end
    n_checks++;
    if (ch_level[0 +: LW] !== 10'd98) begin
      n_fail++; $display("[TB] FAIL abort_level: got %0d expected 98", ch_level[0 +: LW]);
    end
    start_read();
    send_word(d, v, en);
    n_checks++;
    if (d !== 16'hA040 || grant_ch !== 3'd0) begin
      n_fail++; $display("[TB] FAIL abort_regrant: got %h grant=%0d expected A040 grant=0", d, grant_ch);
    end
    send_word(d, v, en);
    n_checks++;
    if (d !== 16'h1042) begin
      n_fail++; $display("[TB] FAIL rst_pre_data: got %h expected 1042", d);
    end
    word_req = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (ch_rd_en !== 4'b0000 || tx_data !== 16'h0000 || tx_valid !== 1'b0 || busy !== 1'b0 || grant_ch !== 3'd3) begin
      n_fail++; $display("[TB] FAIL rst_mid_data: got en=%b tx=%h v=%b busy=%b grant=%0d expected 0000/0000/0/0/3",
                         ch_rd_en, tx_data, tx_valid, busy, grant_ch);
    end
    @(posedge clk);
    #1;
    word_req = 1'b0;
    n_checks++;
    if (pop_cnt[0] !== 10'd67) begin
      n_fail++; $display("[TB] FAIL rst_no_pop: got pops=%0d expected 67", pop_cnt[0]);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_round_robin();
    test_empty();
    test_back_to_back();
    test_fill_start();
    test_abort_and_reset();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
